// File: rtl/exec_mul_ctrl.sv
// rtl/exec_mul_ctrl.sv - execute-stage sequencer with iterative shift-add unsigned multiplier
`ifndef REG_SIZE
`define REG_SIZE 32
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif

module exec_mul_ctrl #(
    parameter int W  = `REG_SIZE,
    parameter int AW = `ADDR_SIZE
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          in_is_mul,
    input  logic [W-1:0]  in_src_a,
    input  logic [W-1:0]  in_src_b,
    input  logic [W-1:0]  in_aluresult,
    input  logic          in_zero,
    input  logic          in_overflow,
    input  logic [AW-1:0] in_new_pc,
    input  logic [4:0]    in_dst,
    output logic          stall,
    output logic          busy,
    output logic          out_valid,
    output logic [W-1:0]  pre_aluresult,
    output logic          pre_zero,
    output logic          pre_overflow,
    output logic [AW-1:0] pre_new_pc,
    output logic [4:0]    pre_dst
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

    state_t          state;
    logic [2*W-1:0]  acc;
    logic [2*W-1:0]  mcand;
    logic [W-1:0]    mplier;
    logic [CW-1:0]   count;
    logic [AW-1:0]   pc_q;
    logic [4:0]      dst_q;
    logic [2*W-1:0]  acc_next;

    // Stall is a pure decode of registered state so decode never sees a combinational loop.
    assign stall = (state == MUL);
    assign busy  = (state == MUL);

    // Partial-product accumulation for the current multiplier bit.
    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // Sequencer: ALU pass-through in IDLE, one shift-add step per cycle in MUL.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            count         <= '0;
            pc_q          <= '0;
            dst_q         <= '0;
            out_valid     <= 1'b0;
            pre_aluresult <= '0;
            pre_zero      <= 1'b0;
            pre_overflow  <= 1'b0;
            pre_new_pc    <= '0;
            pre_dst       <= '0;
        end else if (flush) begin
            // Redirect kills both an in-flight multiply and whatever is being offered now.
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && !in_is_mul) begin
                        pre_aluresult <= in_aluresult;
                        pre_zero      <= in_zero;
                        pre_overflow  <= in_overflow;
                        pre_new_pc    <= in_new_pc;
                        pre_dst       <= in_dst;
                        out_valid     <= 1'b1;
                    end else if (in_valid && in_is_mul) begin
                        acc       <= '0;
                        mcand     <= {{W{1'b0}}, in_src_a};
                        mplier    <= in_src_b;
                        count     <= '0;
                        pc_q      <= in_new_pc;
                        dst_q     <= in_dst;
                        out_valid <= 1'b0;
                        state     <= MUL;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == CW'(W - 1)) begin
                        pre_aluresult <= acc_next[W-1:0];
                        pre_zero      <= (acc_next[W-1:0] == '0);
                        pre_overflow  <= |acc_next[2*W-1:W];
                        pre_new_pc    <= pc_q;
                        pre_dst       <= dst_q;
                        out_valid     <= 1'b1;
                        count         <= '0;
                        state         <= IDLE;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
